fft_dit_sched: RTL and testbench
================================

// Module: fft_dit_sched
// PURPOSE
//  Control and address scheduler for an in-place radix-2 DIT FFT built around the shared two-cycle butterfly_dit.
//  Walks log2(N) stages x N/2 butterflies: issues RAM read pairs, twiddle ROM addresses and delayed write-back addresses.
//  Data never passes through this block. RAM rd_data0/1 feed butterfly in_x0/in_x1, ROM data feeds w, and butterfly out_x0/out_x1 feed RAM wr_data0/1.
//  Input samples are preloaded into the RAM in bit-reversed order before start.
// PARAMETERS
//  N_LOG2     4   log2 of transform size N (N=16 by default); RAM address width = N_LOG2
//  WB_DELAY   5   cycles from read issue to write-back (1 RAM read + 4 butterfly); fixed by butterfly_dit timing
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous, active-low reset
//  start     in   1         request one full FFT; sampled only in IDLE
//  busy      out  1         high from the cycle after start is accepted until done
//  done      out  1         one-cycle pulse after the final write-back
//  phase     out  1         slot phase; must equal butterfly_dit count (0,1,0,1... from reset release)
//  rd_en     out  1         RAM read strobe, both ports
//  rd_addr0  out  N_LOG2    RAM port-0 read address (x0)
//  rd_addr1  out  N_LOG2    RAM port-1 read address (x1)
//  tw_addr   out  N_LOG2-1  twiddle ROM index i; ROM holds W_N^i = e^{-j2*pi*i/N}, Q1.14, 1-cycle latency
//  wr_en     out  1         RAM write strobe, both ports
//  wr_addr0  out  N_LOG2    RAM port-0 write address (out_x0)
//  wr_addr1  out  N_LOG2    RAM port-1 write address (out_x1)
// BEHAVIOUR
//  Reset (rst=0, asynchronous): every output = 0; FSM=IDLE; phase=0; all counters and delay lines cleared.
//  Butterfly reset must release in the same cycle as this block's reset. This keeps phase and count aligned.
//  phase toggles every cycle after reset. Reads are issued only in phase=1 cycles (one butterfly per 2-cycle slot).
//  RAM and ROM are synchronous, 1-cycle read latency, and write-before-read on the same edge.
//  Read data is held stable through the following phase-0 and phase-1 cycles, which is what butterfly_dit requires.
//  FSM states:
//   IDLE  --start=1-->  WAIT.
//   WAIT  --phase=1-->  RUN. Stage s=0, butterfly k=0.
//   RUN   issues one read per phase=1 cycle, k=0..N/2-1. After k=N/2-1 --> DRAIN.
//   DRAIN waits until the stage's last write is complete. Next: s<N_LOG2-1 --> RUN with s+1, k=0; otherwise --> DONE.
//   DONE  pulses done=1 and busy=0 for one cycle --> IDLE.
//  Addressing for stage s, butterfly k (half=2^s):
//   rd_addr0 = ((k>>s)<<(s+1)) | (k & (half-1))
//   rd_addr1 = rd_addr0 + half
//   tw_addr  = (k & (half-1)) << (N_LOG2-1-s)
//   All arithmetic is unsigned, modulo 2^N_LOG2; no carry out of the address width.
//  rd_en=1 only in RUN issue cycles; rd_addr*/tw_addr are meaningful only while rd_en=1 and otherwise hold their last value.
//  Write-back: wr_en=1 for exactly one cycle, WB_DELAY cycles after each read issue, with wr_addr0/1 = that read's rd_addr0/1.
//   A WB_DELAY-deep shift register carries {valid, addr0, addr1}.
//  Stage spacing: first read of stage s+1 comes N+4 cycles after the first read of stage s. This lands on phase=1 and follows the last write of stage s.
//  Timing: let t0 = first read cycle. Final wr_en is at t0 + N_LOG2*(N+4) - 1. done is at t0 + N_LOG2*(N+4).
//  busy=1 from the cycle after start is accepted until the done cycle, where busy=0.
//  start while busy is ignored, with no queuing. start held high re-triggers only after returning to IDLE.
//  Reset mid-run: abandon immediately. No further rd_en or wr_en; RAM contents are undefined; next start begins at stage 0.
// TESTING
//  1 Reset: assert rst=0 mid-cycle -> all outputs 0 asynchronously; phase=0 in the first cycle after release.
//  2 Stage 0, N=16: start -> read pairs (0,1),(2,3)..(14,15) on t0,t0+2..t0+14; tw_addr=0 each; wr_en at t0+5..t0+19 step 2.
//  3 Stage 1 -> pairs (0,2),(1,3),(4,6)..., tw 0,4,0,4... starting t0+20.
//     Stage 3 -> pairs (0,8)..(7,15), tw 0..7, starting t0+60.
//  4 System test with RAM, ROM and butterfly_dit: x[0]=16384 (1.0 real), rest 0 -> every bin 16384+j0.
//     Final wr_en at t0+79; done at t0+80.
//  5 Pulse start again at t0+30 and t0+79 -> ignored; exactly one done pulse; FSM returns to IDLE.
//  6 Reset at t0+45 (stage 2) -> wr_en/rd_en stop at once; new start -> first read pair (0,1) at the new t0.

Source files
------------

// File: rtl/fft_dit_sched.sv
// Address/control scheduler for an in-place radix-2 DIT FFT around a shared two-cycle butterfly.
// One read pair per 2-cycle slot, write-back WB_DELAY cycles later; data never passes through here.
module fft_dit_sched #(
   parameter int N_LOG2   = 4,
   parameter int WB_DELAY = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              phase,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr0,
   output logic [N_LOG2-1:0] rd_addr1,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              wr_en,
   output logic [N_LOG2-1:0] wr_addr0,
   output logic [N_LOG2-1:0] wr_addr1
);
   localparam int KW = N_LOG2 - 1;
   localparam int SW = $clog2(N_LOG2 + 1);
   localparam int CW = $clog2(WB_DELAY + 1);
   localparam logic [KW-1:0] K_LAST  = '1;
   localparam logic [SW-1:0] LAST_S  = SW'(N_LOG2 - 1);
   localparam logic [CW-1:0] DR_RUN  = CW'(WB_DELAY - 1);
   localparam logic [CW-1:0] DR_DONE = CW'(WB_DELAY);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [SW-1:0]             s_q, s_d;
   logic [KW-1:0]             k_q, k_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      busy_q, busy_d, done_q, done_d, phase_q, phase_d;
   logic                      rd_en_q, rd_en_d;
   logic [N_LOG2-1:0]         rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
   logic [KW-1:0]             tw_addr_q, tw_addr_d;
   logic [WB_DELAY-1:0]       wb_vld_q, wb_vld_d;
   logic [WB_DELAY-1:0][N_LOG2-1:0] wb_a0_q, wb_a0_d, wb_a1_q, wb_a1_d;
   logic [N_LOG2-1:0]         k_ext, half_m1, a0;

   always_comb begin
      k_ext   = {1'b0, k_q};
      half_m1 = (N_LOG2'(1) << s_q) - N_LOG2'(1);
      a0      = ((k_ext >> s_q) << (s_q + SW'(1))) | (k_ext & half_m1);

      state_d    = state_q;
      s_d        = s_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      phase_d    = ~phase_q;
      rd_en_d    = 1'b0;
      rd_addr0_d = rd_addr0_q;
      rd_addr1_d = rd_addr1_q;
      tw_addr_d  = tw_addr_q;

      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
         end
         S_WAIT: if (phase_q) begin
            state_d = S_RUN;
            s_d     = '0;
            k_d     = '0;
         end
         // Issue on phase-0 cycles so the registered strobe lands on phase 1.
         S_RUN: if (!phase_q) begin
            rd_en_d    = 1'b1;
            rd_addr0_d = a0;
            rd_addr1_d = a0 + half_m1 + N_LOG2'(1);
            tw_addr_d  = (k_q & half_m1[KW-1:0]) << (LAST_S - s_q);
            k_d        = k_q + KW'(1);
            if (k_q == K_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (s_q != LAST_S && cnt_q == DR_RUN) begin
               state_d = S_RUN;
               s_d     = s_q + SW'(1);
               k_d     = '0;
            end else if (s_q == LAST_S && cnt_q == DR_DONE) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      wb_vld_d = {wb_vld_q[WB_DELAY-2:0], rd_en_q};
      wb_a0_d  = {wb_a0_q[WB_DELAY-2:0], rd_addr0_q};
      wb_a1_d  = {wb_a1_q[WB_DELAY-2:0], rd_addr1_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         s_q        <= '0;
         k_q        <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         phase_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr0_q <= '0;
         rd_addr1_q <= '0;
         tw_addr_q  <= '0;
         wb_vld_q   <= '0;
         wb_a0_q    <= '0;
         wb_a1_q    <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         phase_q    <= phase_d;
         rd_en_q    <= rd_en_d;
         rd_addr0_q <= rd_addr0_d;
         rd_addr1_q <= rd_addr1_d;
         tw_addr_q  <= tw_addr_d;
         wb_vld_q   <= wb_vld_d;
         wb_a0_q    <= wb_a0_d;
         wb_a1_q    <= wb_a1_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign phase    = phase_q;
   assign rd_en    = rd_en_q;
   assign rd_addr0 = rd_addr0_q;
   assign rd_addr1 = rd_addr1_q;
   assign tw_addr  = tw_addr_q;
   assign wr_en    = wb_vld_q[WB_DELAY-1];
   assign wr_addr0 = wb_a0_q[WB_DELAY-1];
   assign wr_addr1 = wb_a1_q[WB_DELAY-1];
endmodule

// File: tb/tb_fft_dit_sched.sv
// Bench for fft_dit_sched: spot-vector table plus per-cycle comparison against a stage/butterfly schedule model.
module tb_fft_dit_sched;
   localparam int N_LOG2 = 4;
   localparam int N      = 16;
   localparam int WB     = 5;
   localparam int SPAN   = N + 4;
   localparam int DONE_D = N_LOG2 * SPAN;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic busy, done, phase, rd_en, wr_en;
   logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
   logic [2:0] tw_addr;

   fft_dit_sched #(.N_LOG2(N_LOG2), .WB_DELAY(WB)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .phase(phase),
      .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
      .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1));

   always #5 clk = ~clk;

   int cyc = 0, since_rel = 0, n_chk = 0, n_fail = 0;
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      since_rel <= rst ? since_rel + 1 : 0;
   end

   typedef struct packed {
      logic busy, done, phase, rd_en;
      logic [3:0] a0, a1;
      logic [2:0] tw;
      logic wr_en;
      logic [3:0] w0, w1;
   } obs_t;

   typedef struct {
      bit is_wr;
      int off, a0, a1, tw;
   } vec_t;

   obs_t cap [0:DONE_D];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Schedule from first principles: stage s spans N+4 cycles, butterfly k reads at offset 2k.
   function automatic void ref_rd(input int d, output bit en, output int a0, output int a1, output int tw);
      int s, r, k, half;
      en = 0; a0 = 0; a1 = 0; tw = 0;
      if (d >= 0 && d < DONE_D) begin
         s = d / SPAN;
         r = d % SPAN;
         if (r < N && r % 2 == 0) begin
            k    = r / 2;
            half = 1 << s;
            en   = 1;
            a0   = (k / half) * 2 * half + k % half;
            a1   = a0 + half;
            tw   = (k % half) * (N / (2 * half));
         end
      end
   endfunction

   function automatic obs_t expect_at(input int d, input logic ph);
      obs_t e;
      bit en;
      int a0, a1, tw;
      e = '0;
      e.phase = ph;
      e.busy  = (d < DONE_D);
      e.done  = (d == DONE_D);
      ref_rd(d, en, a0, a1, tw);
      if (en) begin
         e.rd_en = 1'b1; e.a0 = 4'(a0); e.a1 = 4'(a1); e.tw = 3'(tw);
      end
      ref_rd(d - WB, en, a0, a1, tw);
      if (en) begin
         e.wr_en = 1'b1; e.w0 = 4'(a0); e.w1 = 4'(a1);
      end
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o = '0;
      o.busy = busy; o.done = done; o.phase = phase; o.rd_en = rd_en; o.wr_en = wr_en;
      if (rd_en) begin
         o.a0 = rd_addr0; o.a1 = rd_addr1; o.tw = tw_addr;
      end
      if (wr_en) begin
         o.w0 = wr_addr0; o.w1 = wr_addr1;
      end
      return o;
   endfunction

   function automatic logic [26:0] all_outs();
      return {busy, done, phase, rd_en, rd_addr0, rd_addr1, tw_addr, wr_en, wr_addr0, wr_addr1};
   endfunction

   task automatic reset_mid_cycle(input string name);
      rst = 1'b0;
      #1 check(name, 64'(all_outs()), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("idle_after_reset", 64'({rd_en, wr_en, busy, phase}), 64'({3'b000, 1'(since_rel % 2)}));
         @(negedge clk);
      end
   endtask

   task automatic run_one(input int pre, input bit spur, input bit capture, input int rst_at, input bit hold);
      int w, spur_d;
      bit aborted;
      aborted = 0;
      spur_d  = $urandom_range(1, DONE_D - 2);
      repeat (pre) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      w = 0;
      while (!rd_en && w < 8) begin
         @(negedge clk);
         w++;
      end
      check("first_read_found_on_phase1", 64'({rd_en, phase}), 64'b11);
      if (!rd_en) return;
      for (int d = 0; d <= DONE_D; d++) begin
         check("schedule", 64'(observe()), 64'(expect_at(d, 1'(since_rel % 2))));
         if (capture) cap[d] = observe();
         if (d == rst_at) begin
            reset_mid_cycle("reset_mid_run_outputs");
            aborted = 1;
            break;
         end
         if (!hold) start = spur && (d == 30 || d == 79 || d == spur_d);
         @(negedge clk);
      end
      if (aborted) return;
      if (hold) begin
         check("hold_idle_busy", 64'(busy), 64'd0);
         @(negedge clk);
         check("hold_retrigger_busy", 64'(busy), 64'd1);
         start = 1'b0;
         reset_mid_cycle("reset_after_retrigger");
      end else begin
         start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            check("back_to_idle", 64'({busy, done, rd_en, wr_en}), 64'd0);
            @(negedge clk);
         end
      end
   endtask

   vec_t tbl [17];

   initial begin
      tbl = '{
         '{0, 0, 0, 1, 0},  '{0, 2, 2, 3, 0},   '{0, 14, 14, 15, 0},
         '{0, 20, 0, 2, 0}, '{0, 22, 1, 3, 4},  '{0, 24, 4, 6, 0},  '{0, 34, 13, 15, 4},
         '{0, 42, 1, 5, 2}, '{0, 48, 8, 12, 0}, '{0, 54, 11, 15, 6},
         '{0, 60, 0, 8, 0}, '{0, 62, 1, 9, 1},  '{0, 74, 7, 15, 7},
         '{1, 5, 0, 1, 0},  '{1, 19, 14, 15, 0}, '{1, 25, 0, 2, 0}, '{1, 79, 7, 15, 0}};

      repeat (3) @(negedge clk);
      check("reset_state", 64'(all_outs()), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("phase_after_release", 64'(phase), 64'(i % 2));
         @(negedge clk);
      end

      run_one(3, 0, 1, -1, 0);
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].is_wr)
            check("table_write", 64'({cap[tbl[i].off].wr_en, cap[tbl[i].off].w0, cap[tbl[i].off].w1}),
                  64'({1'b1, 4'(tbl[i].a0), 4'(tbl[i].a1)}));
         else
            check("table_read", 64'({cap[tbl[i].off].rd_en, cap[tbl[i].off].a0, cap[tbl[i].off].a1, cap[tbl[i].off].tw}),
                  64'({1'b1, 4'(tbl[i].a0), 4'(tbl[i].a1), 3'(tbl[i].tw)}));
      end
      check("table_done", 64'({cap[DONE_D].done, cap[DONE_D].busy}), 64'b10);

      run_one(2, 1, 0, -1, 0);
      run_one($urandom_range(0, 4), 0, 0, 45, 0);
      run_one($urandom_range(0, 4), 0, 0, -1, 0);
      run_one($urandom_range(0, 4), 0, 0, -1, 1);
      for (int i = 0; i < 3; i++) run_one($urandom_range(0, 5), 1'($urandom_range(0, 1)), 0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
